reg_trace_buffer: RTL and testbench

Synthesizable trace recorder that sits beside the CPU core and snoops the register-file write port and PC. Qualifying events are stamped with a run-relative cycle number and stored in a DEPTH-entry FIFO, which is drained through a valid/ready port. It replaces per-cycle architectural dumps with a bounded, parametrised capture window, two capture modes, and overflow accounting.

---
 rtl/reg_trace_buffer.sv | 177 +++++++++++++++++
 tb/tb_reg_trace_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_trace_buffer.sv
// reg_trace_buffer
//   Trace recorder that sits beside the CPU core. It snoops the register-file
//   write port and the PC, stamps each qualifying event with a run-relative
//   cycle number, and queues it in a DEPTH-entry FIFO. The FIFO is drained
//   through a valid/ready port.
//
// Ports
//   clk_i, rst_i           clock (rising edge) and asynchronous active-high reset
//   start_i, stop_i        begin a capture run / abort the current run
//   mode_i                 0 = log register writes only, 1 = log every RUN cycle
//   pc_i                   PC of the current cycle
//   rf_we_i/waddr_i/wdata_i  snooped register-file write port
//   out_valid_o/ready_i    FIFO head handshake
//   out_cycle_o/pc_o/rd_o/data_o  FIFO head fields (rd = 0 means no write)
//   count_o                FIFO occupancy, 0..DEPTH
//   overflow_o, dropped_o  sticky drop flag and saturating drop counter
//   state_o                0 = IDLE, 1 = RUN, 2 = DONE
module reg_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 30
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       mode_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic                       rf_we_i,
  input  logic [4:0]                 rf_waddr_i,
  input  logic [XLEN-1:0]            rf_wdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CYC_W-1:0]           out_cycle_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [4:0]                 out_rd_o,
  output logic [XLEN-1:0]            out_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [CYC_W-1:0]           dropped_o,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Window limit; LAST_C is only meaningful when LIMIT_C is set.
  localparam bit               LIMIT_C = (MAX_CYCLES != 0);
  localparam logic [CYC_W-1:0] LAST_C  = CYC_W'(MAX_CYCLES - 1);

  logic [1:0]       state_r, state_nxt_s;
  logic [CYC_W-1:0] cyc_r;
  logic [CYC_W-1:0] dropped_r;
  logic             overflow_r;
  logic             valid_r;
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;

  logic [CYC_W-1:0] mem_cyc_r  [DEPTH];
  logic [XLEN-1:0]  mem_pc_r   [DEPTH];
  logic [4:0]       mem_rd_r   [DEPTH];
  logic [XLEN-1:0]  mem_data_r [DEPTH];

  logic run_s, start_s, wr_s, evt_s, pop_s, full_s, push_s, drop_s, last_s;

  // Event qualification, FIFO push/pop decisions and next state.
  always_comb begin
    run_s   = (state_r == ST_RUN);
    start_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    wr_s    = rf_we_i && (rf_waddr_i != 5'd0);
    // stop_i suppresses the capture in the cycle it is asserted.
    evt_s   = run_s && !stop_i && (mode_i || wr_s);
    pop_s   = valid_r && out_ready_i;
    full_s  = (count_r == CW'(DEPTH));
    // A full FIFO still accepts the event when the head leaves the same cycle.
    push_s  = evt_s && (!full_s || pop_s);
    drop_s  = evt_s && full_s && !pop_s;
    last_s  = LIMIT_C && (cyc_r == LAST_C);

    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end

    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = start_s ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (stop_i) begin
          state_nxt_s = ST_DONE;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = start_s ? ST_RUN : ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state: FSM, cycle stamp, drop accounting and FIFO pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      cyc_r      <= {CYC_W{1'b0}};
      dropped_r  <= {CYC_W{1'b0}};
      overflow_r <= 1'b0;
      valid_r    <= 1'b0;
      count_r    <= {CW{1'b0}};
      wptr_r     <= {AW{1'b0}};
      rptr_r     <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      if (start_s) begin
        cyc_r      <= {CYC_W{1'b0}};
        dropped_r  <= {CYC_W{1'b0}};
        overflow_r <= 1'b0;
      end else begin
        if (run_s && !stop_i) begin
          cyc_r <= cyc_r + CYC_W'(1);
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
          if (dropped_r != {CYC_W{1'b1}}) begin
            dropped_r <= dropped_r + CYC_W'(1);
          end
        end
      end
      if (push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the head fields read 0 afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_cyc_r[i]  <= {CYC_W{1'b0}};
        mem_pc_r[i]   <= {XLEN{1'b0}};
        mem_rd_r[i]   <= 5'd0;
        mem_data_r[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      mem_cyc_r[wptr_r]  <= cyc_r;
      mem_pc_r[wptr_r]   <= pc_i;
      mem_rd_r[wptr_r]   <= wr_s ? rf_waddr_i : 5'd0;
      mem_data_r[wptr_r] <= wr_s ? rf_wdata_i : {XLEN{1'b0}};
    end
  end

  assign out_valid_o = valid_r;
  assign out_cycle_o = mem_cyc_r[rptr_r];
  assign out_pc_o    = mem_pc_r[rptr_r];
  assign out_rd_o    = mem_rd_r[rptr_r];
  assign out_data_o  = mem_data_r[rptr_r];
  assign count_o     = count_r;
  assign overflow_o  = overflow_r;
  assign dropped_o   = dropped_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// tb_reg_trace_buffer
//   Directed bench for reg_trace_buffer. Three instances with different
//   parameters share the snoop inputs; each has its own start_i so only the
//   instance under test leaves IDLE.
//     u0: DEPTH 16, CYC_W 16, MAX_CYCLES 30
//     u1: DEPTH 4,  CYC_W 4,  MAX_CYCLES 0 (unlimited)
//     u2: DEPTH 16, CYC_W 16, MAX_CYCLES 4
module tb_reg_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        stop = 1'b0, mode = 1'b0, ready = 1'b0;
  logic [31:0] pc = 32'd0, wdata = 32'd0;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;

  logic v0, ov0; logic [15:0] cyc0, drp0; logic [31:0] pc0, dat0;
  logic [4:0] rd0, cnt0; logic [1:0] st0;
  logic v1, ov1; logic [3:0] cyc1, drp1; logic [31:0] pc1, dat1;
  logic [4:0] rd1; logic [2:0] cnt1; logic [1:0] st1;
  logic v2, ov2; logic [15:0] cyc2, drp2; logic [31:0] pc2, dat2;
  logic [4:0] rd2, cnt2; logic [1:0] st2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_trace_buffer #(.DEPTH(16), .CYC_W(16), .MAX_CYCLES(30)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .stop_i(stop), .mode_i(mode),
    .pc_i(pc), .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
    .out_valid_o(v0), .out_ready_i(ready), .out_cycle_o(cyc0), .out_pc_o(pc0),
    .out_rd_o(rd0), .out_data_o(dat0), .count_o(cnt0), .overflow_o(ov0),
    .dropped_o(drp0), .state_o(st0));

  reg_trace_buffer #(.DEPTH(4), .CYC_W(4), .MAX_CYCLES(0)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .stop_i(stop), .mode_i(mode),
    .pc_i(pc), .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
    .out_valid_o(v1), .out_ready_i(ready), .out_cycle_o(cyc1), .out_pc_o(pc1),
    .out_rd_o(rd1), .out_data_o(dat1), .count_o(cnt1), .overflow_o(ov1),
    .dropped_o(drp1), .state_o(st1));

  reg_trace_buffer #(.DEPTH(16), .CYC_W(16), .MAX_CYCLES(4)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .stop_i(stop), .mode_i(mode),
    .pc_i(pc), .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
    .out_valid_o(v2), .out_ready_i(ready), .out_cycle_o(cyc2), .out_pc_o(pc2),
    .out_rd_o(rd2), .out_data_o(dat2), .count_o(cnt2), .overflow_o(ov2),
    .dropped_o(drp2), .state_o(st2));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check_val("rst_valid", v0, 0);
    check_val("rst_count", cnt0, 0);
    check_val("rst_state", st0, 0);
    check_val("rst_pc", pc0, 0);
    check_val("rst_ovf", ov0, 0);
    tick();
    rst = 1'b0;

    // Mode 0, write-only log on u0
    mode = 1'b0; ready = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    check_val("m0_state_run", st0, 1);
    tick(); tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'd7; pc = 32'h100;
    tick();
    check_val("m0_valid", v0, 1);
    check_val("m0_cycle", cyc0, 2);
    check_val("m0_rd", rd0, 5);
    check_val("m0_data", dat0, 7);
    check_val("m0_pc", pc0, 32'h100);
    waddr = 5'd0; wdata = 32'd9;
    tick();
    we = 1'b0;
    check_val("m0_x0_count", cnt0, 0);
    check_val("m0_x0_valid", v0, 0);
    for (int i = 0; i < 25; i++) tick();
    check_val("m0_still_run", st0, 1);
    tick();
    check_val("m0_done", st0, 2);

    // Mode 1, every cycle, window of 4 on u2
    do_reset();
    mode = 1'b1; ready = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h200 + 32'(4 * i); we = (i == 1); waddr = 5'd3; wdata = 32'hAA;
      tick();
    end
    we = 1'b0;
    check_val("m1_count", cnt2, 4);
    check_val("m1_done", st2, 2);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("m1_cycle", cyc2, i);
      check_val("m1_pc", pc2, 32'h200 + 32'(4 * i));
      check_val("m1_rd", rd2, (i == 1) ? 3 : 0);
      check_val("m1_data", dat2, (i == 1) ? 32'hAA : 0);
      tick();
    end
    check_val("m1_drained", cnt2, 0);

    // Overflow with concurrent pop on u1 (DEPTH 4)
    do_reset();
    mode = 1'b1; ready = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_val("ov_count", cnt1, 4);
    check_val("ov_flag", ov1, 1);
    check_val("ov_dropped", drp1, 2);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_val("ov_pop_count", cnt1, 4);
    check_val("ov_pop_dropped", drp1, 2);
    check_val("ov_pop_head", cyc1, 3);
    ready = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    check_val("ov_stop", st1, 2);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check_val("ov_restart_state", st1, 1);
    check_val("ov_restart_flag", ov1, 0);
    check_val("ov_restart_drop", drp1, 0);
    check_val("ov_restart_kept", cnt1, 4);
    stop = 1'b1; tick(); stop = 1'b0;

    // Early stop and restart on u0
    do_reset();
    mode = 1'b0; ready = 1'b0;
    start0 = 1'b1; tick(); start0 = 1'b0;
    we = 1'b1; waddr = 5'd1; wdata = 32'h11; pc = 32'h300;
    tick();
    we = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    we = 1'b1; waddr = 5'd2; wdata = 32'h22; stop = 1'b1;
    tick();
    we = 1'b0; stop = 1'b0;
    check_val("es_state", st0, 2);
    check_val("es_count", cnt0, 1);
    start0 = 1'b1; tick(); start0 = 1'b0;
    check_val("es_restart", st0, 1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h44; pc = 32'h400;
    tick();
    we = 1'b0;
    check_val("es_count2", cnt0, 2);
    check_val("es_old_rd", rd0, 1);
    check_val("es_old_data", dat0, 32'h11);
    ready = 1'b1; tick(); ready = 1'b0;
    check_val("es_new_rd", rd0, 4);
    check_val("es_new_cycle", cyc0, 0);
    check_val("es_new_data", dat0, 32'h44);

    // Asynchronous reset mid-run on u0
    do_reset();
    mode = 1'b0; ready = 1'b0;
    start0 = 1'b1; tick(); start0 = 1'b0;
    we = 1'b1; waddr = 5'd6; wdata = 32'h66; pc = 32'h500;
    for (int i = 0; i < 3; i++) tick();
    we = 1'b0;
    check_val("ar_count_pre", cnt0, 3);
    #2 rst = 1'b1;
    #1;
    check_val("ar_count", cnt0, 0);
    check_val("ar_valid", v0, 0);
    check_val("ar_state", st0, 0);
    check_val("ar_rd", rd0, 0);
    check_val("ar_pc", pc0, 0);
    check_val("ar_data", dat0, 0);
    rst = 1'b0;

    // Unlimited window and stamp wrap on u1 (CYC_W 4)
    do_reset();
    mode = 1'b1; ready = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("wr_stamp", cyc1, i % 16);
    end
    check_val("wr_state", st1, 1);
    stop = 1'b1; tick(); stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
